// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned multiply/divide sequencer beside the EX stage.
// One bit per cycle through a single shared adder/subtractor and a shift
// register pair. Multiply is shift-add; divide is restoring.
// Optional feature macro: MDU_DIV_EN enables the divide datapath. When it is
// undefined, divide requests complete immediately with zero results and
// div_zero set.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] mat_cop_res,
  output logic [XLEN-1:0] res_hi,
  output logic            div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  // acc_hi: product high half / partial remainder.
  // acc_lo: multiplier being consumed / dividend shifting into quotient.
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  // Operand held for the whole run: multiplicand or divisor.
  logic [XLEN-1:0] opnd;
`ifdef MDU_DIV_EN
  logic            op_div;
`endif

  logic [XLEN:0]   alu_a;
  logic [XLEN:0]   alu_b;
  logic [XLEN:0]   alu_sum;
  logic [XLEN-1:0] nxt_hi;
  logic [XLEN-1:0] nxt_lo;
  logic            xfer;

  assign req_ready = (state != RUN) && !rst && !flush;
  assign xfer      = req_valid && req_ready;
  assign busy      = (state == RUN);
  assign res_valid = (state == DONE);

  // One iteration step: shared adder feeds the next shift-register contents.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    alu_a   = {1'b0, acc_hi};
    alu_b   = {1'b0, (acc_lo[0] ? opnd : '0)};
    alu_sum = alu_a + alu_b;
    // Multiply: keep the carry in bit XLEN, then shift the 2*XLEN+1 value right.
    nxt_hi  = alu_sum[XLEN:1];
    nxt_lo  = {alu_sum[0], acc_lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
    if (op_div) begin
      // Shift the next dividend bit into the remainder, then trial-subtract.
      alu_a   = {acc_hi, acc_lo[XLEN-1]};
      alu_b   = {1'b0, opnd};
      alu_sum = alu_a - alu_b;
      if (alu_sum[XLEN]) begin
        // Borrow: remainder < divisor, restore and shift in a 0 quotient bit.
        nxt_hi = alu_a[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        nxt_hi = alu_sum[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end
    end
`endif
  end

  // Sequencer FSM, iteration registers and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
`ifdef MDU_DIV_EN
      op_div      <= 1'b0;
`endif
      mat_cop_res <= '0;
      res_hi      <= '0;
      div_zero    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            // Squash: results from the previous operation stay visible.
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state       <= DONE;
              mat_cop_res <= nxt_lo;
              res_hi      <= nxt_hi;
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike: accept a new request or fall to IDLE.
          if (xfer) begin
            cnt      <= '0;
            div_zero <= 1'b0;
            if (req_op) begin
`ifdef MDU_DIV_EN
              if (rt_val == '0) begin
                // Divide by zero bypasses iteration entirely.
                state       <= DONE;
                mat_cop_res <= '1;
                res_hi      <= rs_val;
                div_zero    <= 1'b1;
              end else begin
                state  <= RUN;
                op_div <= 1'b1;
                acc_hi <= '0;
                acc_lo <= rs_val;
                opnd   <= rt_val;
              end
`else
              // No divider: flag the request and finish immediately.
              state       <= DONE;
              mat_cop_res <= '0;
              res_hi      <= '0;
              div_zero    <= 1'b1;
`endif
            end else begin
              state  <= RUN;
`ifdef MDU_DIV_EN
              op_div <= 1'b0;
`endif
              acc_hi <= '0;
              acc_lo <= rt_val;
              opnd   <= rs_val;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed, table-driven bench for mdu_seq plus hand-written
// sequences for flush, reset mid-run and back-to-back issue.
// Divide expectations follow MDU_DIV_EN the same way the design does.
module tb_mdu_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            res_valid;
  logic [XLEN-1:0] mat_cop_res;
  logic [XLEN-1:0] res_hi;
  logic            div_zero;

  int checks   = 0;
  int failures = 0;

  mdu_seq #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .busy       (busy),
    .res_valid  (res_valid),
    .mat_cop_res(mat_cop_res),
    .res_hi     (res_hi),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic            dz;
    int              lat;
    int              nbusy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Present a request at the current sample point; accepted on the next edge.
  task automatic issue(input logic op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    rs_val    = a;
    rt_val    = b;
    check("req_ready_at_issue", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Starting at cycle T+1, count cycles until res_valid and busy cycles seen.
  task automatic wait_result(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!res_valid && lat < 60) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int              lat;
  int              nbusy;
  int              strobes;
  logic [XLEN-1:0] last_lo;
  logic [XLEN-1:0] last_hi;

  initial begin
    // Multiplies: exact 64-bit products split into low/high halves.
    vecs[0] = '{1'b0, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 32'h0000_0000, 1'b0, 33, 32};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 32};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 1'b0, 33, 32};
    vecs[3] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b0, 33, 32};
`ifdef MDU_DIV_EN
    vecs[4] = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33, 32};
    vecs[5] = '{1'b1, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1,  0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, 32};
    vecs[8] = '{1'b1, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 33, 32};
`else
    vecs[4] = '{1'b1, 32'd100,       32'd7,         32'd0,         32'd0,         1'b1, 1,  0};
    vecs[5] = '{1'b1, 32'h0000_1234, 32'h0000_0000, 32'd0,         32'd0,         1'b1, 1,  0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0,         32'd0,         1'b1, 1,  0};
    vecs[8] = '{1'b1, 32'd5,         32'd9,         32'd0,         32'd0,         1'b1, 1,  0};
`endif
    // A multiply after a divide-by-zero clears div_zero.
    vecs[6] = '{1'b0, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0, 33, 32};
    vecs[9] = '{1'b0, 32'd6,         32'd7,         32'd42,        32'd0,         1'b0, 33, 32};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    rs_val    = '0;
    rt_val    = '0;
    flush     = 1'b0;

    // Reset state.
    step(2);
    check("ready_in_reset", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_lo", 64'(mat_cop_res), 64'd0);
    check("rst_hi", 64'(res_hi), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("ready_after_reset", 64'(req_ready), 64'd1);
    step(1);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_result(lat, nbusy);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(nbusy), 64'(vecs[i].nbusy));
      check($sformatf("v%0d_lo", i), 64'(mat_cop_res), 64'(vecs[i].lo));
      check($sformatf("v%0d_hi", i), 64'(res_hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
      step(1);
      check($sformatf("v%0d_strobe_one_cycle", i), 64'(res_valid), 64'd0);
      step(1);
    end
    last_lo = vecs[9].lo;
    last_hi = vecs[9].hi;

    // Flush during RUN at T+10: IDLE at T+11, no strobe, results retained.
    issue(1'b0, 32'd3, 32'd4);
    step(9);
    check("flush_busy_at_t10", 64'(busy), 64'd1);
    flush = 1'b1;
    check("flush_blocks_ready", 64'(req_ready), 64'd0);
    step(1);
    flush = 1'b0;
    check("flush_busy_cleared", 64'(busy), 64'd0);
    check("flush_no_strobe", 64'(res_valid), 64'd0);
    check("flush_lo_kept", 64'(mat_cop_res), 64'(last_lo));
    check("flush_hi_kept", 64'(res_hi), 64'(last_hi));
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) strobes++;
      step(1);
    end
    check("flush_no_late_strobe", 64'(strobes), 64'd0);

    // Flush while IDLE blocks acceptance.
    req_valid = 1'b1;
    req_op    = 1'b0;
    rs_val    = 32'd9;
    rt_val    = 32'd9;
    flush     = 1'b1;
    #1;
    check("idle_flush_ready", 64'(req_ready), 64'd0);
    step(1);
    req_valid = 1'b0;
    flush     = 1'b0;
    check("idle_flush_not_accepted", 64'(busy), 64'd0);
    step(1);

    // Reset at T+20 of a multiply: all outputs return to reset values.
    issue(1'b0, 32'd7, 32'd9);
    step(19);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    check("rst_mid_lo", 64'(mat_cop_res), 64'd0);
    check("rst_mid_hi", 64'(res_hi), 64'd0);
    check("rst_mid_div_zero", 64'(div_zero), 64'd0);
    step(1);

    // Back-to-back: second request held during the first DONE cycle.
    issue(1'b0, 32'd6, 32'd7);
    wait_result(lat, nbusy);
    check("b2b_first_latency", 64'(lat), 64'd33);
    check("b2b_first_lo", 64'(mat_cop_res), 64'd42);
    req_valid = 1'b1;
    req_op    = 1'b0;
    rs_val    = 32'h0001_0000;
    rt_val    = 32'h0001_0000;
    #1;
    check("b2b_ready_in_done", 64'(req_ready), 64'd1);
    check("b2b_first_strobe", 64'(res_valid), 64'd1);
    step(1);
    req_valid = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'd1);
    check("b2b_second_no_strobe", 64'(res_valid), 64'd0);
    wait_result(lat, nbusy);
    check("b2b_second_latency", 64'(lat), 64'd33);
    check("b2b_second_lo", 64'(mat_cop_res), 64'h0000_0000);
    check("b2b_second_hi", 64'(res_hi), 64'h0000_0001);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
